// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: one outstanding imem request, FWFT instruction queue, PC advance/redirect.
// Optional performance counters enabled by defining IF_FETCH_PERF_CNT_EN.
module if_fetch_stage #(
   parameter int DEPTH = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_pc,
   output logic        o_pc_wr_en,
   output logic [31:0] o_pc_next,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ack,
   input  logic [31:0] i_imem_rdata,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic        o_valid,
   output logic [31:0] o_instr,
   output logic [31:0] o_instr_pc,
   input  logic        i_ready
`ifdef IF_FETCH_PERF_CNT_EN
   ,
   output logic [31:0] o_perf_fetched,
   output logic [31:0] o_perf_flushed
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_HOLD  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t             state_r;
   state_t             state_nxt_s;
   logic [31:0]        addr_r;
   logic [CNT_W-1:0]   count_r;
   logic [CNT_W-1:0]   count_nxt_s;
   logic [PTR_W-1:0]   rd_ptr_r;
   logic [PTR_W-1:0]   wr_ptr_r;
   logic [31:0]        instr_q_r [DEPTH];
   logic [31:0]        pc_q_r    [DEPTH];
   logic               ack_s;
   logic               push_s;
   logic               pop_s;
   logic               discard_s;

   assign o_valid    = (count_r != {CNT_W{1'b0}});
   assign o_instr    = instr_q_r[rd_ptr_r];
   assign o_instr_pc = pc_q_r[rd_ptr_r];

   // Handshake decode, PC write port, queue count and next-state logic.
   always_comb begin
      o_imem_req  = 1'b0;
      o_imem_addr = i_pc;
      o_pc_wr_en  = 1'b0;
      o_pc_next   = i_pc + 32'd4;
      state_nxt_s = state_r;
      count_nxt_s = count_r;
      // An ack with no request outstanding (S_HOLD) or during reset is ignored.
      ack_s     = i_imem_ack && !i_rst && (state_r != S_HOLD);
      push_s    = ack_s && (state_r == S_REQ) && !i_redirect;
      discard_s = ack_s && ((state_r == S_DRAIN) || i_redirect);
      pop_s     = o_valid && i_ready && !i_rst;

      if (i_rst) begin
         o_imem_req = 1'b0;
      end else begin
         o_imem_req = (state_r == S_REQ) || (state_r == S_DRAIN);
      end

      if (state_r == S_DRAIN) begin
         o_imem_addr = addr_r;
      end else begin
         o_imem_addr = i_pc;
      end

      if (i_rst) begin
         o_pc_wr_en = 1'b0;
      end else if (i_redirect) begin
         o_pc_wr_en = 1'b1;
         o_pc_next  = i_redirect_pc;
      end else if (push_s) begin
         o_pc_wr_en = 1'b1;
      end else begin
         o_pc_wr_en = 1'b0;
      end

      if (i_redirect) begin
         count_nxt_s = {CNT_W{1'b0}};
      end else begin
         case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
         endcase
      end

      case (state_r)
         S_REQ: begin
            if (i_redirect) begin
               state_nxt_s = ack_s ? S_REQ : S_DRAIN;
            end else if (push_s && (count_nxt_s == CNT_FULL)) begin
               state_nxt_s = S_HOLD;
            end else begin
               state_nxt_s = S_REQ;
            end
         end
         S_HOLD: begin
            if (i_redirect || (count_nxt_s < CNT_FULL)) begin
               state_nxt_s = S_REQ;
            end else begin
               state_nxt_s = S_HOLD;
            end
         end
         S_DRAIN: begin
            state_nxt_s = ack_s ? S_REQ : S_DRAIN;
         end
         default: state_nxt_s = S_REQ;
      endcase
   end

   // FSM, queue pointers and the drain address register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r  <= S_REQ;
         count_r  <= {CNT_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         wr_ptr_r <= {PTR_W{1'b0}};
         addr_r   <= 32'd0;
      end else begin
         state_r <= state_nxt_s;
         count_r <= count_nxt_s;
         if (state_r == S_REQ) begin
            addr_r <= i_pc;
         end
         if (i_redirect) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
         end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
      end
   end

   // Queue storage; contents are qualified by count_r so no reset is needed.
   always_ff @(posedge i_clk) begin
      if (push_s) begin
         instr_q_r[wr_ptr_r] <= i_imem_rdata;
         pc_q_r[wr_ptr_r]    <= i_pc;
      end
   end

`ifdef IF_FETCH_PERF_CNT_EN
   logic [31:0] flush_inc_s;

   // Flushed = entries still queued after this cycle's pop, plus any dropped response.
   always_comb begin
      if (i_redirect && !i_rst) begin
         flush_inc_s = 32'(count_r) - 32'(pop_s) + 32'(discard_s);
      end else begin
         flush_inc_s = 32'(discard_s);
      end
   end

   // Free-running performance counters.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_perf_fetched <= 32'd0;
         o_perf_flushed <= 32'd0;
      end else begin
         o_perf_fetched <= o_perf_fetched + 32'(push_s);
         o_perf_flushed <= o_perf_flushed + flush_inc_s;
      end
   end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed self-checking bench for if_fetch_stage (DEPTH=2), with a PC register model in front.
module tb_if_fetch_stage;

   logic        i_clk;
   logic        i_rst;
   logic [31:0] pc_r;
   logic        o_pc_wr_en;
   logic [31:0] o_pc_next;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_ack;
   logic [31:0] i_imem_rdata;
   logic        i_redirect;
   logic [31:0] i_redirect_pc;
   logic        o_valid;
   logic [31:0] o_instr;
   logic [31:0] o_instr_pc;
   logic        i_ready;
`ifdef IF_FETCH_PERF_CNT_EN
   logic [31:0] o_perf_fetched;
   logic [31:0] o_perf_flushed;
`endif

   int checks = 0;
   int errors = 0;

   if_fetch_stage #(.DEPTH(2)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_pc(pc_r),
      .o_pc_wr_en(o_pc_wr_en), .o_pc_next(o_pc_next),
      .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
      .i_imem_ack(i_imem_ack), .i_imem_rdata(i_imem_rdata),
      .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
      .o_valid(o_valid), .o_instr(o_instr), .o_instr_pc(o_instr_pc),
      .i_ready(i_ready)
`ifdef IF_FETCH_PERF_CNT_EN
      , .o_perf_fetched(o_perf_fetched), .o_perf_flushed(o_perf_flushed)
`endif
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Upstream PC register, written through the stage's write port.
   always @(posedge i_clk) begin
      if (i_rst) pc_r <= 32'h0;
      else if (o_pc_wr_en) pc_r <= o_pc_next;
   end

   task automatic next_cycle();
      @(negedge i_clk);
   endtask

   task automatic do_reset();
      i_rst = 1'b1; i_imem_ack = 1'b0; i_imem_rdata = 32'h0;
      i_redirect = 1'b0; i_redirect_pc = 32'h0; i_ready = 1'b0;
      repeat (2) next_cycle();
      i_rst = 1'b0;
   endtask

   task automatic test_reset();
      i_rst = 1'b1; i_imem_ack = 1'b1; i_imem_rdata = 32'hFFFF_FFFF;
      i_redirect = 1'b1; i_redirect_pc = 32'h0000_0040; i_ready = 1'b0;
      repeat (3) next_cycle();
      #1;
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", o_valid); end
      checks++; if (o_imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", o_imem_req); end
      checks++; if (o_pc_wr_en !== 1'b0) begin errors++; $display("FAIL rst_pcwr: got %b want 0", o_pc_wr_en); end
      checks++; if (pc_r !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", pc_r); end
`ifdef IF_FETCH_PERF_CNT_EN
      checks++; if (o_perf_fetched !== 32'h0 || o_perf_flushed !== 32'h0) begin errors++;
         $display("FAIL rst_perf: got %h/%h want 0/0", o_perf_fetched, o_perf_flushed); end
`endif
   endtask

   task automatic test_stream();
      do_reset();
      for (int k = 0; k < 6; k++) begin
         i_imem_ack = 1'b1; i_imem_rdata = 32'h1000_0000 + 32'(4 * k); i_ready = 1'b1;
         #1;
         checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'(4 * k)) begin errors++;
            $display("FAIL stream_req[%0d]: got %b/%h want 1/%h", k, o_imem_req, o_imem_addr, 32'(4 * k)); end
         checks++; if (o_pc_wr_en !== 1'b1 || o_pc_next !== 32'(4 * k + 4)) begin errors++;
            $display("FAIL stream_pcnext[%0d]: got %b/%h want 1/%h", k, o_pc_wr_en, o_pc_next, 32'(4 * k + 4)); end
         if (k == 0) begin
            checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL stream_first_valid: got %b want 0", o_valid); end
         end else begin
            checks++; if (o_valid !== 1'b1 || o_instr_pc !== 32'(4 * (k - 1)) || o_instr !== 32'h1000_0000 + 32'(4 * (k - 1))) begin
               errors++; $display("FAIL stream_head[%0d]: got %b/%h/%h want 1/%h/%h", k, o_valid, o_instr_pc, o_instr,
                                  32'(4 * (k - 1)), 32'h1000_0000 + 32'(4 * (k - 1))); end
         end
         next_cycle();
      end
`ifdef IF_FETCH_PERF_CNT_EN
      #1;
      checks++; if (o_perf_fetched !== 32'd6) begin errors++; $display("FAIL stream_fetched: got %0d want 6", o_perf_fetched); end
`endif
   endtask

   task automatic test_hold();
      do_reset();
      i_ready = 1'b0; i_imem_ack = 1'b1; i_imem_rdata = 32'h2000_0000;
      #1;
      checks++; if (o_imem_addr !== 32'h0 || o_valid !== 1'b0) begin errors++;
         $display("FAIL hold_c0: got addr %h valid %b want 0/0", o_imem_addr, o_valid); end
      next_cycle();
      i_imem_rdata = 32'h2000_0004;
      #1;
      checks++; if (o_imem_addr !== 32'h4 || o_valid !== 1'b1 || o_instr_pc !== 32'h0) begin errors++;
         $display("FAIL hold_c1: got addr %h valid %b pc %h want 4/1/0", o_imem_addr, o_valid, o_instr_pc); end
      next_cycle();
      i_imem_ack = 1'b0;
      #1;
      checks++; if (o_imem_req !== 1'b0 || o_pc_wr_en !== 1'b0) begin errors++;
         $display("FAIL hold_noreq: got req %b pcwr %b want 0/0", o_imem_req, o_pc_wr_en); end
      checks++; if (o_instr !== 32'h2000_0000 || pc_r !== 32'h8) begin errors++;
         $display("FAIL hold_head: got instr %h pc %h want 20000000/8", o_instr, pc_r); end
      next_cycle();
      i_ready = 1'b1;
      #1;
      checks++; if (o_imem_req !== 1'b0 || o_instr_pc !== 32'h0) begin errors++;
         $display("FAIL hold_stable: got req %b pc %h want 0/0", o_imem_req, o_instr_pc); end
      next_cycle();
      i_ready = 1'b0;
      #1;
      checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h8) begin errors++;
         $display("FAIL hold_resume: got req %b addr %h want 1/8", o_imem_req, o_imem_addr); end
      checks++; if (o_instr_pc !== 32'h4 || o_instr !== 32'h2000_0004) begin errors++;
         $display("FAIL hold_next_head: got %h/%h want 4/20000004", o_instr_pc, o_instr); end
   endtask

   task automatic test_drain();
      do_reset();
      i_ready = 1'b1; i_imem_ack = 1'b0; i_redirect = 1'b1; i_redirect_pc = 32'h0000_0100;
      #1;
      checks++; if (o_pc_wr_en !== 1'b1 || o_pc_next !== 32'h100) begin errors++;
         $display("FAIL drain_redir: got %b/%h want 1/100", o_pc_wr_en, o_pc_next); end
      next_cycle();
      i_redirect = 1'b0;
      for (int k = 0; k < 2; k++) begin
         #1;
         checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0 || o_pc_wr_en !== 1'b0) begin errors++;
            $display("FAIL drain_wait[%0d]: got req %b addr %h pcwr %b want 1/0/0", k, o_imem_req, o_imem_addr, o_pc_wr_en); end
         next_cycle();
      end
      i_imem_ack = 1'b1; i_imem_rdata = 32'hBAD0_0000;
      #1;
      checks++; if (o_pc_wr_en !== 1'b0 || o_imem_addr !== 32'h0) begin errors++;
         $display("FAIL drain_ack: got pcwr %b addr %h want 0/0", o_pc_wr_en, o_imem_addr); end
      next_cycle();
      i_imem_ack = 1'b0;
      #1;
      checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h100 || o_valid !== 1'b0 || pc_r !== 32'h100) begin errors++;
         $display("FAIL drain_after: got req %b addr %h valid %b pc %h want 1/100/0/100", o_imem_req, o_imem_addr, o_valid, pc_r); end
`ifdef IF_FETCH_PERF_CNT_EN
      checks++; if (o_perf_flushed !== 32'd1 || o_perf_fetched !== 32'd0) begin errors++;
         $display("FAIL drain_perf: got %0d/%0d want 0/1", o_perf_fetched, o_perf_flushed); end
`endif
   endtask

   task automatic test_redirect_ack();
      do_reset();
      i_ready = 1'b0; i_imem_ack = 1'b1; i_imem_rdata = 32'h3000_0000;
      next_cycle();
      i_imem_rdata = 32'h3000_0004; i_redirect = 1'b1; i_redirect_pc = 32'h0000_0040;
      #1;
      checks++; if (o_valid !== 1'b1 || o_pc_wr_en !== 1'b1 || o_pc_next !== 32'h40) begin errors++;
         $display("FAIL redack_pc: got valid %b pcwr %b next %h want 1/1/40", o_valid, o_pc_wr_en, o_pc_next); end
      next_cycle();
      i_redirect = 1'b0; i_imem_ack = 1'b0;
      #1;
      checks++; if (o_valid !== 1'b0 || o_imem_req !== 1'b1 || o_imem_addr !== 32'h40 || pc_r !== 32'h40) begin errors++;
         $display("FAIL redack_after: got valid %b req %b addr %h pc %h want 0/1/40/40", o_valid, o_imem_req, o_imem_addr, pc_r); end
`ifdef IF_FETCH_PERF_CNT_EN
      checks++; if (o_perf_fetched !== 32'd1 || o_perf_flushed !== 32'd2) begin errors++;
         $display("FAIL redack_perf: got %0d/%0d want 1/2", o_perf_fetched, o_perf_flushed); end
`endif
   endtask

   task automatic test_back_to_back();
      do_reset();
      i_ready = 1'b1; i_imem_ack = 1'b0; i_redirect = 1'b1; i_redirect_pc = 32'h0000_0200;
      next_cycle();
      i_redirect_pc = 32'h0000_0300;
      #1;
      checks++; if (o_pc_next !== 32'h300 || o_imem_addr !== 32'h0 || o_imem_req !== 1'b1) begin errors++;
         $display("FAIL b2b_second: got next %h addr %h req %b want 300/0/1", o_pc_next, o_imem_addr, o_imem_req); end
      next_cycle();
      i_redirect = 1'b0; i_imem_ack = 1'b1; i_imem_rdata = 32'hBAD0_0001;
      #1;
      checks++; if (o_imem_addr !== 32'h0 || o_pc_wr_en !== 1'b0) begin errors++;
         $display("FAIL b2b_drain: got addr %h pcwr %b want 0/0", o_imem_addr, o_pc_wr_en); end
      next_cycle();
      i_imem_ack = 1'b0;
      #1;
      checks++; if (o_imem_addr !== 32'h300 || o_imem_req !== 1'b1 || o_valid !== 1'b0) begin errors++;
         $display("FAIL b2b_target: got addr %h req %b valid %b want 300/1/0", o_imem_addr, o_imem_req, o_valid); end
   endtask

   task automatic test_rst_in_drain();
      do_reset();
      i_ready = 1'b0; i_imem_ack = 1'b1; i_imem_rdata = 32'h4000_0000;
      next_cycle();
      i_imem_ack = 1'b0; i_redirect = 1'b1; i_redirect_pc = 32'h0000_0500;
      next_cycle();
      i_redirect = 1'b0;
      #1;
      checks++; if (o_imem_addr !== 32'h4 || o_imem_req !== 1'b1) begin errors++;
         $display("FAIL rstdrain_pre: got addr %h req %b want 4/1", o_imem_addr, o_imem_req); end
      i_rst = 1'b1;
      #1;
      checks++; if (o_imem_req !== 1'b0) begin errors++; $display("FAIL rstdrain_req_gate: got %b want 0", o_imem_req); end
      next_cycle();
      i_imem_ack = 1'b1; i_imem_rdata = 32'hBAD0_0002;
      #1;
      checks++; if (o_imem_req !== 1'b0 || o_pc_wr_en !== 1'b0 || o_valid !== 1'b0) begin errors++;
         $display("FAIL rstdrain_outs: got req %b pcwr %b valid %b want 0/0/0", o_imem_req, o_pc_wr_en, o_valid); end
      next_cycle();
      i_rst = 1'b0; i_imem_ack = 1'b0;
      #1;
      checks++; if (o_valid !== 1'b0 || o_imem_req !== 1'b1 || o_imem_addr !== 32'h0) begin errors++;
         $display("FAIL rstdrain_after: got valid %b req %b addr %h want 0/1/0", o_valid, o_imem_req, o_imem_addr); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_stream();
      test_hold();
      test_drain();
      test_redirect_ack();
      test_back_to_back();
      test_rst_in_drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
